// File: rtl/fazyrv_wb_arb_if.sv
// Wishbone bundle for the two-master arbiter: imem and dmem master ports plus
// the shared memory bus. The slave modport is the arbiter's view; the master
// modport is the view of the core and the memory behind the arbiter.
interface fazyrv_wb_arb_if;
  logic        wb_imem_cyc_i;
  logic        wb_imem_stb_i;
  logic [31:0] wb_imem_adr_i;
  logic [31:0] wb_imem_dat_o;
  logic        wb_imem_ack_o;

  logic        wb_dmem_cyc_i;
  logic        wb_dmem_stb_i;
  logic        wb_dmem_we_i;
  logic [3:0]  wb_dmem_be_i;
  logic [31:0] wb_dmem_adr_i;
  logic [31:0] wb_dmem_dat_i;
  logic [31:0] wb_dmem_dat_o;
  logic        wb_dmem_ack_o;

  logic        wb_mem_cyc_o;
  logic        wb_mem_stb_o;
  logic        wb_mem_we_o;
  logic [3:0]  wb_mem_be_o;
  logic [31:0] wb_mem_adr_o;
  logic [31:0] wb_mem_dat_o;
  logic [31:0] wb_mem_dat_i;
  logic        wb_mem_ack_i;

  modport slave (
    input  wb_imem_cyc_i, wb_imem_stb_i, wb_imem_adr_i,
    output wb_imem_dat_o, wb_imem_ack_o,
    input  wb_dmem_cyc_i, wb_dmem_stb_i, wb_dmem_we_i, wb_dmem_be_i,
    input  wb_dmem_adr_i, wb_dmem_dat_i,
    output wb_dmem_dat_o, wb_dmem_ack_o,
    output wb_mem_cyc_o, wb_mem_stb_o, wb_mem_we_o, wb_mem_be_o,
    output wb_mem_adr_o, wb_mem_dat_o,
    input  wb_mem_dat_i, wb_mem_ack_i
  );

  modport master (
    output wb_imem_cyc_i, wb_imem_stb_i, wb_imem_adr_i,
    input  wb_imem_dat_o, wb_imem_ack_o,
    output wb_dmem_cyc_i, wb_dmem_stb_i, wb_dmem_we_i, wb_dmem_be_i,
    output wb_dmem_adr_i, wb_dmem_dat_i,
    input  wb_dmem_dat_o, wb_dmem_ack_o,
    input  wb_mem_cyc_o, wb_mem_stb_o, wb_mem_we_o, wb_mem_be_o,
    input  wb_mem_adr_o, wb_mem_dat_o,
    output wb_mem_dat_i, wb_mem_ack_i
  );
endinterface

// File: rtl/fazyrv_wb_arb.sv
// Two-master Wishbone classic arbiter: merges the imem fetch bus and the dmem
// data bus onto one shared memory bus. A grant lasts a full transaction; the
// shared-bus request is registered on grant entry and held until ack, abort,
// or timeout. PRIO selects round-robin ("RR") or fixed dmem priority ("DMEM").
module fazyrv_wb_arb #(
  parameter string       PRIO    = "RR",
  parameter int unsigned TIMEOUT = 0
) (
  input  logic           clk_i,
  input  logic           rst_in,
  fazyrv_wb_arb_if.slave wb,
  output logic           tout_o
);

  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam int unsigned     CW       = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;
  localparam bit              DPRIO    = (PRIO == "DMEM");

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;
  typedef enum logic {LAST_I, LAST_D} last_e;

  state_e        state_q, state_d;
  last_e         last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        cyc_q, stb_q, we_q;
  logic [3:0]  be_q;
  logic [31:0] adr_q, dat_q;

  logic req_i, req_d, granted, gcyc, ack_fwd, tmo;

  assign req_i   = wb.wb_imem_cyc_i & wb.wb_imem_stb_i;
  assign req_d   = wb.wb_dmem_cyc_i & wb.wb_dmem_stb_i;
  assign granted = (state_q != IDLE);
  assign gcyc    = (state_q == GNT_I) ? wb.wb_imem_cyc_i : wb.wb_dmem_cyc_i;
  // A master that drops cyc has aborted: nothing is forwarded to it anymore.
  assign ack_fwd = granted & gcyc & wb.wb_mem_ack_i;
  assign tmo     = TO_EN & granted & gcyc & ~wb.wb_mem_ack_i & (cnt_q == CNT_LAST);

  // Next-state, round-robin bookkeeping, and timeout counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_i && req_d) begin
          if (DPRIO || last_q == LAST_I) state_d = GNT_D;
          else                           state_d = GNT_I;
        end else if (req_i) begin
          state_d = GNT_I;
        end else if (req_d) begin
          state_d = GNT_D;
        end
        if (state_d == GNT_I) last_d = LAST_I;
        if (state_d == GNT_D) last_d = LAST_D;
      end
      GNT_I, GNT_D: begin
        if (!wb.wb_mem_ack_i) cnt_d = cnt_q + CW'(1);
        if (!gcyc || wb.wb_mem_ack_i || tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q <= IDLE;
      last_q  <= LAST_D;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shared-bus request: captured from the winner on grant entry, held for the grant.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      be_q  <= '0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (state_q == IDLE && state_d == GNT_I) begin
      cyc_q <= 1'b1;
      stb_q <= 1'b1;
      we_q  <= 1'b0;
      be_q  <= '1;
      adr_q <= wb.wb_imem_adr_i;
      dat_q <= '0;
    end else if (state_q == IDLE && state_d == GNT_D) begin
      cyc_q <= 1'b1;
      stb_q <= 1'b1;
      we_q  <= wb.wb_dmem_we_i;
      be_q  <= wb.wb_dmem_be_i;
      adr_q <= wb.wb_dmem_adr_i;
      dat_q <= wb.wb_dmem_dat_i;
    end else if (state_d == IDLE) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
    end
  end

  assign wb.wb_mem_cyc_o = cyc_q;
  assign wb.wb_mem_stb_o = stb_q;
  assign wb.wb_mem_we_o  = we_q;
  assign wb.wb_mem_be_o  = be_q;
  assign wb.wb_mem_adr_o = adr_q;
  assign wb.wb_mem_dat_o = dat_q;

  // Return path: ack and read data go only to the granted master.
  always_comb begin
    wb.wb_imem_ack_o = 1'b0;
    wb.wb_imem_dat_o = '0;
    wb.wb_dmem_ack_o = 1'b0;
    wb.wb_dmem_dat_o = '0;
    tout_o           = tmo;
    if (state_q == GNT_I) begin
      wb.wb_imem_ack_o = ack_fwd | tmo;
      if (!tmo) wb.wb_imem_dat_o = wb.wb_mem_dat_i;
    end else if (state_q == GNT_D) begin
      wb.wb_dmem_ack_o = ack_fwd | tmo;
      if (!tmo) wb.wb_dmem_dat_o = wb.wb_mem_dat_i;
    end
  end

endmodule

// File: tb/tb_fazyrv_wb_arb.sv
// Bench for fazyrv_wb_arb: an RR/TIMEOUT=4 instance (A) and a DMEM-priority
// instance (B) share master stimulus. A cycle table covers conflicts; directed
// sequences on A cover single fetch, abort, timeout and reset.
module tb_fazyrv_wb_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        icyc, dcyc, dwe;
  logic [3:0]  dbe;
  logic [31:0] iadr, dadr, ddat;
  logic        a_auto, a_ack;
  logic [31:0] a_dat;
  logic        tout_a, tout_b;

  localparam logic [31:0] B_DAT = 32'h1234_5678;

  int checks = 0;
  int errors = 0;

  fazyrv_wb_arb_if bus_a();
  fazyrv_wb_arb_if bus_b();

  assign bus_a.wb_imem_cyc_i = icyc;
  assign bus_a.wb_imem_stb_i = icyc;
  assign bus_a.wb_imem_adr_i = iadr;
  assign bus_a.wb_dmem_cyc_i = dcyc;
  assign bus_a.wb_dmem_stb_i = dcyc;
  assign bus_a.wb_dmem_we_i  = dwe;
  assign bus_a.wb_dmem_be_i  = dbe;
  assign bus_a.wb_dmem_adr_i = dadr;
  assign bus_a.wb_dmem_dat_i = ddat;
  assign bus_a.wb_mem_ack_i  = a_auto ? bus_a.wb_mem_cyc_o : a_ack;
  assign bus_a.wb_mem_dat_i  = a_dat;

  assign bus_b.wb_imem_cyc_i = icyc;
  assign bus_b.wb_imem_stb_i = icyc;
  assign bus_b.wb_imem_adr_i = iadr;
  assign bus_b.wb_dmem_cyc_i = dcyc;
  assign bus_b.wb_dmem_stb_i = dcyc;
  assign bus_b.wb_dmem_we_i  = dwe;
  assign bus_b.wb_dmem_be_i  = dbe;
  assign bus_b.wb_dmem_adr_i = dadr;
  assign bus_b.wb_dmem_dat_i = ddat;
  assign bus_b.wb_mem_ack_i  = bus_b.wb_mem_cyc_o;
  assign bus_b.wb_mem_dat_i  = B_DAT;

  fazyrv_wb_arb #(.PRIO("RR"), .TIMEOUT(4)) dut_a (
    .clk_i(clk), .rst_in(rst_n), .wb(bus_a), .tout_o(tout_a)
  );
  fazyrv_wb_arb #(.PRIO("DMEM"), .TIMEOUT(0)) dut_b (
    .clk_i(clk), .rst_in(rst_n), .wb(bus_b), .tout_o(tout_b)
  );

  typedef struct {
    logic ireq;
    logic dreq;
    int   ga;   // expected grant on A: 0 none, 1 imem, 2 dmem
    int   gb;   // expected grant on B
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected bus state for a grant code with a slave that acks in the granted cycle.
  task automatic chk_bus(input string t, input int g, input logic [31:0] sdat,
                         input logic cyc, input logic stb, input logic we,
                         input logic [3:0] be, input logic [31:0] adr, input logic [31:0] dat,
                         input logic iack, input logic dack,
                         input logic [31:0] idat, input logic [31:0] dd);
    chk({t, ".cyc"},  {31'b0, cyc},  (g != 0) ? 32'd1 : 32'd0);
    chk({t, ".stb"},  {31'b0, stb},  (g != 0) ? 32'd1 : 32'd0);
    chk({t, ".iack"}, {31'b0, iack}, (g == 1) ? 32'd1 : 32'd0);
    chk({t, ".dack"}, {31'b0, dack}, (g == 2) ? 32'd1 : 32'd0);
    chk({t, ".idat"}, idat, (g == 1) ? sdat : 32'd0);
    chk({t, ".ddat"}, dd,   (g == 2) ? sdat : 32'd0);
    if (g != 0) begin
      chk({t, ".adr"}, adr, (g == 1) ? 32'h100 : 32'h2000);
      chk({t, ".we"},  {31'b0, we}, (g == 2) ? 32'd1 : 32'd0);
      chk({t, ".be"},  {28'b0, be}, (g == 2) ? 32'h3 : 32'hF);
      chk({t, ".dat"}, dat, (g == 2) ? 32'hCAFE_BABE : 32'd0);
    end
  endtask

  task automatic chk_a(input string t, input int g);
    chk_bus({"A.", t}, g, a_dat, bus_a.wb_mem_cyc_o, bus_a.wb_mem_stb_o, bus_a.wb_mem_we_o,
            bus_a.wb_mem_be_o, bus_a.wb_mem_adr_o, bus_a.wb_mem_dat_o,
            bus_a.wb_imem_ack_o, bus_a.wb_dmem_ack_o, bus_a.wb_imem_dat_o, bus_a.wb_dmem_dat_o);
  endtask

  task automatic chk_b(input string t, input int g);
    chk_bus({"B.", t}, g, B_DAT, bus_b.wb_mem_cyc_o, bus_b.wb_mem_stb_o, bus_b.wb_mem_we_o,
            bus_b.wb_mem_be_o, bus_b.wb_mem_adr_o, bus_b.wb_mem_dat_o,
            bus_b.wb_imem_ack_o, bus_b.wb_dmem_ack_o, bus_b.wb_imem_dat_o, bus_b.wb_dmem_dat_o);
  endtask

  // Every bus output of A at its reset value.
  task automatic chk_a_reset(input string t);
    chk({t, ".cyc"},  {31'b0, bus_a.wb_mem_cyc_o}, 32'd0);
    chk({t, ".stb"},  {31'b0, bus_a.wb_mem_stb_o}, 32'd0);
    chk({t, ".we"},   {31'b0, bus_a.wb_mem_we_o},  32'd0);
    chk({t, ".be"},   {28'b0, bus_a.wb_mem_be_o},  32'd0);
    chk({t, ".adr"},  bus_a.wb_mem_adr_o, 32'd0);
    chk({t, ".dat"},  bus_a.wb_mem_dat_o, 32'd0);
    chk({t, ".iack"}, {31'b0, bus_a.wb_imem_ack_o}, 32'd0);
    chk({t, ".dack"}, {31'b0, bus_a.wb_dmem_ack_o}, 32'd0);
    chk({t, ".idat"}, bus_a.wb_imem_dat_o, 32'd0);
    chk({t, ".ddat"}, bus_a.wb_dmem_dat_o, 32'd0);
    chk({t, ".tout"}, {31'b0, tout_a}, 32'd0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; icyc = 1'b0; dcyc = 1'b0;
    iadr = 32'h100; dadr = 32'h2000; ddat = 32'hCAFE_BABE; dbe = 4'h3; dwe = 1'b1;
    a_auto = 1'b1; a_ack = 1'b0; a_dat = B_DAT;

    vecs.push_back('{1'b0, 1'b0, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1, 2});
    vecs.push_back('{1'b1, 1'b1, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 2, 2});
    vecs.push_back('{1'b1, 1'b1, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1, 2});
    vecs.push_back('{1'b1, 1'b0, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1, 1});
    vecs.push_back('{1'b1, 1'b1, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 2, 2});
    vecs.push_back('{1'b0, 1'b0, 0, 0});
    vecs.push_back('{1'b0, 1'b0, 0, 0});

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_a_reset("rst0");
    chk("B.rst0.cyc", {31'b0, bus_b.wb_mem_cyc_o}, 32'd0);
    nxt();

    // Conflict table, zero-wait slaves on both instances.
    foreach (vecs[k]) begin
      icyc = vecs[k].ireq;
      dcyc = vecs[k].dreq;
      @(negedge clk);
      chk_a($sformatf("row%0d", k), vecs[k].ga);
      chk_b($sformatf("row%0d", k), vecs[k].gb);
      chk($sformatf("A.row%0d.tout", k), {31'b0, tout_a}, 32'd0);
      nxt();
    end

    // Single fetch, slave acks two cycles after cyc; request held despite input change.
    a_auto = 1'b0; a_ack = 1'b0; a_dat = 32'h0000_0013; icyc = 1'b1;
    @(negedge clk); chk("fetch.c0.cyc", {31'b0, bus_a.wb_mem_cyc_o}, 32'd0); nxt();
    iadr = 32'h200;
    @(negedge clk);
    chk("fetch.c1.cyc", {31'b0, bus_a.wb_mem_cyc_o}, 32'd1);
    chk("fetch.c1.adr", bus_a.wb_mem_adr_o, 32'h100);
    chk("fetch.c1.we",  {31'b0, bus_a.wb_mem_we_o}, 32'd0);
    chk("fetch.c1.be",  {28'b0, bus_a.wb_mem_be_o}, 32'hF);
    chk("fetch.c1.iack", {31'b0, bus_a.wb_imem_ack_o}, 32'd0);
    nxt();
    @(negedge clk);
    chk("fetch.c2.adr", bus_a.wb_mem_adr_o, 32'h100);
    chk("fetch.c2.iack", {31'b0, bus_a.wb_imem_ack_o}, 32'd0);
    nxt();
    a_ack = 1'b1;
    @(negedge clk);
    chk("fetch.c3.iack", {31'b0, bus_a.wb_imem_ack_o}, 32'd1);
    chk("fetch.c3.idat", bus_a.wb_imem_dat_o, 32'h0000_0013);
    chk("fetch.c3.dack", {31'b0, bus_a.wb_dmem_ack_o}, 32'd0);
    chk("fetch.c3.tout", {31'b0, tout_a}, 32'd0);
    nxt();
    a_ack = 1'b0; icyc = 1'b0; iadr = 32'h100;
    @(negedge clk);
    chk("fetch.c4.cyc", {31'b0, bus_a.wb_mem_cyc_o}, 32'd0);
    chk("fetch.c4.iack", {31'b0, bus_a.wb_imem_ack_o}, 32'd0);
    nxt();

    // Abort by imem, late ack in IDLE, then a normal dmem grant.
    icyc = 1'b1; a_dat = 32'hA5A5_0001; nxt();
    @(negedge clk); chk("abort.c1.cyc", {31'b0, bus_a.wb_mem_cyc_o}, 32'd1); nxt();
    icyc = 1'b0;
    @(negedge clk); chk("abort.c2.iack", {31'b0, bus_a.wb_imem_ack_o}, 32'd0); nxt();
    a_ack = 1'b1;
    @(negedge clk);
    chk("abort.c3.cyc",  {31'b0, bus_a.wb_mem_cyc_o}, 32'd0);
    chk("abort.c3.iack", {31'b0, bus_a.wb_imem_ack_o}, 32'd0);
    chk("abort.c3.dack", {31'b0, bus_a.wb_dmem_ack_o}, 32'd0);
    nxt();
    a_ack = 1'b0; dcyc = 1'b1;
    @(negedge clk); chk("abort.c4.cyc", {31'b0, bus_a.wb_mem_cyc_o}, 32'd0); nxt();
    a_ack = 1'b1;
    @(negedge clk); chk_a("abort.c5", 2); nxt();
    a_ack = 1'b0; dcyc = 1'b0;
    @(negedge clk); chk("abort.c6.cyc", {31'b0, bus_a.wb_mem_cyc_o}, 32'd0); nxt();

    // Timeout: no ack, then ack arriving in the terminating cycle.
    for (int r = 0; r < 2; r++) begin
      dcyc = 1'b1; a_dat = (r == 0) ? 32'hDEAD_BEEF : 32'h55AA_55AA; nxt();
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        chk($sformatf("tmo%0d.c%0d.cyc", r, c),  {31'b0, bus_a.wb_mem_cyc_o}, 32'd1);
        chk($sformatf("tmo%0d.c%0d.dack", r, c), {31'b0, bus_a.wb_dmem_ack_o}, 32'd0);
        chk($sformatf("tmo%0d.c%0d.tout", r, c), {31'b0, tout_a}, 32'd0);
        nxt();
      end
      a_ack = (r == 1);
      @(negedge clk);
      chk($sformatf("tmo%0d.c4.cyc", r),  {31'b0, bus_a.wb_mem_cyc_o}, 32'd1);
      chk($sformatf("tmo%0d.c4.dack", r), {31'b0, bus_a.wb_dmem_ack_o}, 32'd1);
      chk($sformatf("tmo%0d.c4.ddat", r), bus_a.wb_dmem_dat_o, (r == 0) ? 32'd0 : 32'h55AA_55AA);
      chk($sformatf("tmo%0d.c4.tout", r), {31'b0, tout_a}, (r == 0) ? 32'd1 : 32'd0);
      nxt();
      a_ack = 1'b0; dcyc = 1'b0;
      @(negedge clk);
      chk($sformatf("tmo%0d.c5.cyc", r),  {31'b0, bus_a.wb_mem_cyc_o}, 32'd0);
      chk($sformatf("tmo%0d.c5.tout", r), {31'b0, tout_a}, 32'd0);
      nxt();
    end

    // Reset during GNT_D, then a conflict must go to imem first.
    dcyc = 1'b1; nxt();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst.c1.cyc", {31'b0, bus_a.wb_mem_cyc_o}, 32'd1);
    chk("rst.c1.dat", bus_a.wb_mem_dat_o, 32'hCAFE_BABE);
    nxt();
    rst_n = 1'b1; icyc = 1'b1;
    @(negedge clk); chk_a_reset("rst.c2"); nxt();
    a_ack = 1'b1; a_dat = 32'h0BAD_F00D;
    @(negedge clk); chk_a("rst.c3", 1); nxt();
    a_ack = 1'b0; icyc = 1'b0; dcyc = 1'b0;
    @(negedge clk); chk("rst.c4.cyc", {31'b0, bus_a.wb_mem_cyc_o}, 32'd0); nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
